// File: rtl/mod257_accum.sv
// Frame accumulator feeding the mod-257 reducer: sums signed terms into a wide
// unreduced total, then presents it until the reducer stage takes it.
module mod257_accum #(
  parameter int MAX_TERMS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_data,
  input  logic        in_sub,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_data,
  output logic [6:0]  out_count,
  output logic        out_forced,
  output logic        range_err
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_TERMS);

  typedef enum logic {ACC, HOLD} state_t;

  typedef struct packed {
    logic [14:0] sum;
    logic [6:0]  cnt;
    logic        forced;
  } frame_t;

  state_t state_q, state_d;
  frame_t frm_q;
  logic   rerr_q;

  logic               accept, release_frm, closing, hit_max, term_illegal;
  logic        [6:0]  cnt_inc;
  logic signed [8:0]  term_s;
  logic        [14:0] term_ext;

  assign term_s       = in_data;
  assign term_ext     = {{6{in_data[8]}}, in_data};
  assign cnt_inc      = frm_q.cnt + 7'd1;
  assign hit_max      = (cnt_inc == MAX_CNT);
  assign accept       = in_valid && (state_q == ACC);
  assign release_frm  = out_ready && (state_q == HOLD);
  assign closing      = accept && (in_last || hit_max);
  // Legal reduced residues are -128..+128; anything else still gets summed.
  assign term_illegal = (term_s > 9'sd128) || (term_s < -9'sd128);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (closing) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACC;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_q  <= '0;
      rerr_q <= 1'b0;
    end else if (accept) begin
      frm_q.sum <= in_sub ? (frm_q.sum - term_ext) : (frm_q.sum + term_ext);
      frm_q.cnt <= cnt_inc;
      // An explicit last term wins over reaching the cap on the same edge.
      if (closing) frm_q.forced <= ~in_last;
      if (term_illegal) rerr_q <= 1'b1;
    end else if (release_frm) begin
      frm_q <= '0;
    end
  end

  assign in_ready   = (state_q == ACC);
  assign out_valid  = (state_q == HOLD);
  assign out_data   = frm_q.sum;
  assign out_count  = frm_q.cnt;
  assign out_forced = frm_q.forced;
  assign range_err  = rerr_q;

endmodule

// File: tb/tb_mod257_accum.sv
// Scoreboard bench for mod257_accum: driver feeds terms into an integer frame
// model that queues expected sums; a monitor checks each presented frame.
module tb_mod257_accum;
  localparam int MAXT = 64;

  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_sub = 0, in_last = 0, out_ready = 0;
  logic [8:0]  in_data = '0;
  logic        in_ready, out_valid, out_forced, range_err;
  logic [14:0] out_data;
  logic [6:0]  out_count;

  mod257_accum #(.MAX_TERMS(MAXT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_forced(out_forced), .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int count; bit forced; bit rerr; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int m_sum = 0, m_cnt = 0;
  bit m_rerr = 0;
  int hold_block = 0;
  bit in_hold = 0;
  int held = 0;
  int last_data = 0, last_count = 0, last_forced = 0;
  int w;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int wrap15(int s);
    int v;
    v = s & 32'h7fff;
    if (v >= 16384) v -= 32768;
    return v;
  endfunction

  function automatic void model_accept(int d, bit sub, bit last);
    exp_t e;
    m_sum += sub ? -d : d;
    m_cnt++;
    if (d > 128 || d < -128) m_rerr = 1;
    if (last || m_cnt == MAXT) begin
      e.data = wrap15(m_sum); e.count = m_cnt; e.forced = !last; e.rerr = m_rerr;
      q.push_back(e);
      m_sum = 0; m_cnt = 0;
    end
  endfunction

  task automatic send_term(input int d, input bit sub, input bit last, output int waited);
    @(negedge clk);
    in_valid = 1; in_data = 9'(d); in_sub = sub; in_last = last;
    waited = 0;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    else model_accept(d, sub, last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0; in_data = 9'($urandom); in_sub = 1'($urandom); in_last = 1'($urandom);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 0, 1);
  endtask

  task automatic rand_terms(input int n, input int last_mod);
    for (int i = 0; i < n; i++) begin
      send_term($urandom_range(0, 256) - 128, 1'($urandom),
                (last_mod > 0) && ($urandom_range(0, last_mod - 1) == 0), w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    send_term($urandom_range(0, 256) - 128, 1'($urandom), 1, w);
    idle(1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_count"}, out_count, 0);
    check({tag, "_out_forced"}, out_forced, 0);
    check({tag, "_range_err"}, range_err, 0);
  endtask

  // Monitor: pops on the first cycle of each presented frame, then checks hold behaviour.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      in_hold = 0; out_ready = 0;
    end else if (out_valid) begin
      if (!in_hold) begin
        in_hold = 1;
        if (q.size() == 0) check("unexpected_frame", 1, 0);
        else begin
          e = q.pop_front();
          check("frame_data", $signed(out_data), e.data);
          check("frame_count", out_count, e.count);
          check("frame_forced", out_forced, e.forced);
          check("frame_range_err", range_err, e.rerr);
        end
        held = int'({out_data, out_count, out_forced});
        last_data = $signed(out_data); last_count = out_count; last_forced = out_forced;
      end else begin
        check("hold_stable", int'({out_data, out_count, out_forced}), held);
      end
      check("in_ready_in_hold", in_ready, 0);
      if (hold_block > 0) begin
        out_ready = 0; hold_block--;
      end else out_ready = ($urandom_range(0, 3) != 0);
      if (out_ready) in_hold = 0;
    end else begin
      in_hold = 0;
      out_ready = 1'($urandom);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 0;

    // Small mixed frame; out_valid on the closing edge.
    send_term(100, 0, 0, w);
    check("first_accept_wait", w, 0);
    send_term(28, 0, 0, w);
    send_term(5, 1, 1, w);
    @(negedge clk); in_valid = 0;
    check("latency_out_valid", out_valid, 1);
    wait_drain();
    check("d034_data", last_data, 123);
    check("d034_count", last_count, 3);
    check("d034_forced", last_forced, 0);

    // Cap reached with no last: forced close at +8192.
    for (int i = 0; i < 64; i++) send_term(128, 0, 0, w);
    idle(1); wait_drain();
    check("d035_data", last_data, 8192);
    check("d035_count", last_count, 64);
    check("d035_forced", last_forced, 1);

    // Last on the 64th term is not a forced close.
    for (int i = 0; i < 64; i++) send_term(128, 1, i == 63, w);
    idle(1); wait_drain();
    check("d039_data", last_data, -8192);
    check("d039_count", last_count, 64);
    check("d039_forced", last_forced, 0);

    // Backpressured hold with in_valid high; next term must start a fresh frame.
    hold_block = 10;
    send_term(40, 0, 0, w);
    send_term(3, 1, 1, w);
    send_term(9, 0, 1, w);
    check("d036_wait_ge10", w >= 10, 1);
    idle(1); wait_drain();
    check("d036_data", last_data, 9);
    check("d036_count", last_count, 1);

    // Reset mid-frame discards the partial sum.
    for (int i = 0; i < 5; i++) send_term($urandom_range(0, 256) - 128, 1'($urandom), 0, w);
    @(negedge clk); in_valid = 0; rst = 1;
    #1;
    check_idle_outputs("midrst");
    m_sum = 0; m_cnt = 0; m_rerr = 0;
    @(negedge clk); rst = 0;
    send_term(7, 0, 1, w);
    check("post_rst_wait", w, 0);
    idle(1); wait_drain();
    check("d038_data", last_data, 7);
    check("d038_count", last_count, 1);

    // Randomized legal traffic, short frames then long forced runs.
    rand_terms(200, 8);
    rand_terms(150, 0);
    wait_drain();
    check("rand_range_err_clear", range_err, 0);

    // Subtracting -128 and the sticky range error.
    send_term(-128, 1, 1, w);
    idle(1); wait_drain();
    check("d037_data", last_data, 128);
    check("d037_count", last_count, 1);
    send_term(200, 0, 1, w);
    idle(1);
    check("d037_range_err_set", range_err, 1);
    wait_drain();
    check("d037_data_illegal", last_data, 200);
    rand_terms(30, 6);
    wait_drain();
    check("d037_range_err_sticky", range_err, 1);
    @(negedge clk); rst = 1;
    #1;
    check("d037_range_err_rst", range_err, 0);
    @(negedge clk); rst = 0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
